seq_ram_ctrl: RTL and testbench

Controller that owns one nucleotide-sequence RAM (A or B) of the Needleman-Wunsch engine. It runs the load of a sequence from the host, counts its length, and then shares the single registered read port between the matrix-fill engine and the traceback unit with round-robin arbitration. Two instances sit in the top level, one per sequence, between the host interface and the NW datapath.

---
 rtl/nw_pkg.sv | 22 ++
 rtl/seq_ram.sv | 37 +++
 rtl/seq_ram_ctrl.sv | 149 ++++++++++++++
 tb/tb_seq_ram_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
// rtl/nw_pkg.sv - shared symbol codes, FSM encoding and owner constants for the NW sequence RAMs
package nw_pkg;

    localparam logic [2:0] SYM_G = 3'b001;
    localparam logic [2:0] SYM_C = 3'b110;
    localparam logic [2:0] SYM_A = 3'b100;
    localparam logic [2:0] SYM_T = 3'b011;

    localparam logic OWN_FILL  = 1'b0;
    localparam logic OWN_TRACE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    function automatic logic is_valid_sym(input logic [2:0] sym);
        return (sym == SYM_G) || (sym == SYM_C) || (sym == SYM_A) || (sym == SYM_T);
    endfunction

endpackage

// File: rtl/seq_ram.sv
// rtl/seq_ram.sv - N x 3 symbol array with synchronous write and registered, enabled read
module seq_ram #(
    parameter int N   = 128,
    parameter int Bit = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_we,
    input  logic [Bit-1:0] i_waddr,
    input  logic [2:0]     i_wdata,
    input  logic           i_re,
    input  logic [Bit-1:0] i_raddr,
    output logic [2:0]     o_dout
);

    logic [2:0] r_mem [N];
    logic [2:0] r_dout;

    assign o_dout = r_dout;

    // Array write; contents survive reset on purpose
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; holds its value when not enabled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dout <= 3'b000;
        end else if (i_re) begin
            r_dout <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/seq_ram_ctrl.sv
// rtl/seq_ram_ctrl.sv - sequence load FSM, length counter and fill/traceback read arbiter
module seq_ram_ctrl
    import nw_pkg::*;
#(
    parameter int N   = 128,
    parameter int Bit = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_start,
    input  logic           ld_valid,
    input  logic [2:0]     ld_sym,
    input  logic           ld_last,
    output logic           ld_ready,
    output logic           ld_err,
    input  logic           fill_req,
    input  logic [Bit-1:0] fill_addr,
    output logic           fill_gnt,
    input  logic           trace_req,
    input  logic [Bit-1:0] trace_addr,
    output logic           trace_gnt,
    output logic [2:0]     dout,
    output logic           dout_valid,
    output logic           dout_owner,
    output logic           dout_oob,
    output logic [Bit:0]   seq_len,
    output logic           seq_loaded
);

    state_t         r_state;
    state_t         w_next;
    logic [Bit:0]   r_seq_len;
    logic           r_loaded;
    logic           r_err;
    logic           r_last;
    logic           r_dvalid;
    logic           r_owner;
    logic           r_oob;

    logic           w_ld_ready;
    logic           w_sym_ok;
    logic           w_accept;
    logic           w_fill_gnt;
    logic           w_trace_gnt;
    logic           w_gnt;
    logic [Bit-1:0] w_rd_addr;
    logic           w_oob;
    logic [2:0]     w_ram_dout;

    assign w_ld_ready = (r_state == ST_LOAD) && (r_seq_len < (Bit+1)'(N));
    assign w_sym_ok   = is_valid_sym(ld_sym);
    // ld_start takes priority: a symbol presented alongside it is dropped
    assign w_accept   = w_ld_ready && ld_valid && !ld_start;
    assign w_gnt      = w_fill_gnt || w_trace_gnt;
    assign w_rd_addr  = w_trace_gnt ? trace_addr : fill_addr;
    assign w_oob      = ({1'b0, w_rd_addr} >= r_seq_len);

    // Next state and round-robin grants; ld_start overrides everything
    always_comb begin
        w_next      = r_state;
        w_fill_gnt  = 1'b0;
        w_trace_gnt = 1'b0;
        if (ld_start) begin
            w_next = ST_LOAD;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_LOAD: begin
                    if (w_accept && (ld_last || (w_sym_ok && (r_seq_len == (Bit+1)'(N-1))))) begin
                        w_next = ST_READY;
                    end
                end
                ST_READY: begin
                    w_fill_gnt  = fill_req  && (!trace_req || (r_last == OWN_TRACE));
                    w_trace_gnt = trace_req && (!fill_req  || (r_last == OWN_FILL));
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Length counter, sticky error and loaded flag
    always_ff @(posedge clk) begin
        if (rst || ld_start) begin
            r_seq_len <= '0;
            r_loaded  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept && w_sym_ok) begin
                r_seq_len <= r_seq_len + (Bit+1)'(1);
            end
            if (w_accept && !w_sym_ok) begin
                r_err <= 1'b1;
            end
            if ((r_state == ST_LOAD) && (w_next == ST_READY)) begin
                r_loaded <= 1'b1;
            end
        end
    end

    // Read-side tags and round-robin pointer; only granted cycles move them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvalid <= 1'b0;
            r_owner  <= OWN_FILL;
            r_oob    <= 1'b0;
            r_last   <= OWN_TRACE;
        end else begin
            r_dvalid <= w_gnt;
            if (w_gnt) begin
                r_owner <= w_trace_gnt ? OWN_TRACE : OWN_FILL;
                r_oob   <= w_oob;
                r_last  <= w_trace_gnt ? OWN_TRACE : OWN_FILL;
            end
        end
    end

    seq_ram #(.N(N), .Bit(Bit)) u_ram (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_accept && w_sym_ok),
        .i_waddr (r_seq_len[Bit-1:0]),
        .i_wdata (ld_sym),
        .i_re    (w_gnt && !w_oob),
        .i_raddr (w_rd_addr),
        .o_dout  (w_ram_dout)
    );

    assign ld_ready   = w_ld_ready;
    assign ld_err     = r_err;
    assign fill_gnt   = w_fill_gnt;
    assign trace_gnt  = w_trace_gnt;
    assign dout       = r_oob ? 3'b000 : w_ram_dout;
    assign dout_valid = r_dvalid;
    assign dout_owner = r_owner;
    assign dout_oob   = r_oob;
    assign seq_len    = r_seq_len;
    assign seq_loaded = r_loaded;

endmodule

// File: tb/tb_seq_ram_ctrl.sv
// tb/tb_seq_ram_ctrl.sv - directed table-driven bench for seq_ram_ctrl
module tb_seq_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [2:0] ld_sym = 3'b000;
    logic       fill_req = 1'b0, trace_req = 1'b0;
    logic [6:0] fill_addr = '0, trace_addr = '0;
    logic       ld_ready, ld_err, fill_gnt, trace_gnt, dout_valid, dout_owner, dout_oob, seq_loaded;
    logic [2:0] dout;
    logic [7:0] seq_len;

    logic       s_ld_start = 1'b0, s_ld_valid = 1'b0, s_ld_last = 1'b0;
    logic [2:0] s_ld_sym = 3'b000;
    logic       s_fill_req = 1'b0, s_trace_req = 1'b0;
    logic [2:0] s_fill_addr = '0, s_trace_addr = '0;
    logic       s_ld_ready, s_ld_err, s_fill_gnt, s_trace_gnt, s_dout_valid, s_dout_owner, s_dout_oob, s_seq_loaded;
    logic [2:0] s_dout;
    logic [3:0] s_seq_len;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       fr;
        logic [6:0] fa;
        logic       tr;
        logic [6:0] ta;
        logic       egf;
        logic       egt;
        logic       edv;
        logic [2:0] ed;
        logic       eo;
        logic       eoob;
    } vec_t;

    vec_t tab1 [13];
    vec_t tab2 [2];

    always #5 clk = ~clk;

    seq_ram_ctrl #(.N(128)) u_dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_sym(ld_sym),
        .ld_last(ld_last), .ld_ready(ld_ready), .ld_err(ld_err), .fill_req(fill_req),
        .fill_addr(fill_addr), .fill_gnt(fill_gnt), .trace_req(trace_req),
        .trace_addr(trace_addr), .trace_gnt(trace_gnt), .dout(dout), .dout_valid(dout_valid),
        .dout_owner(dout_owner), .dout_oob(dout_oob), .seq_len(seq_len), .seq_loaded(seq_loaded)
    );

    seq_ram_ctrl #(.N(5)) u_small (
        .clk(clk), .rst(rst), .ld_start(s_ld_start), .ld_valid(s_ld_valid), .ld_sym(s_ld_sym),
        .ld_last(s_ld_last), .ld_ready(s_ld_ready), .ld_err(s_ld_err), .fill_req(s_fill_req),
        .fill_addr(s_fill_addr), .fill_gnt(s_fill_gnt), .trace_req(s_trace_req),
        .trace_addr(s_trace_addr), .trace_gnt(s_trace_gnt), .dout(s_dout), .dout_valid(s_dout_valid),
        .dout_owner(s_dout_owner), .dout_oob(s_dout_oob), .seq_len(s_seq_len), .seq_loaded(s_seq_loaded)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load;
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_sym   = 3'b011;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        chk("start_len", int'(seq_len), 0);
        chk("start_ready", int'(ld_ready), 1);
        chk("start_err", int'(ld_err), 0);
        chk("start_loaded", int'(seq_loaded), 0);
    endtask

    task automatic send(input logic [2:0] sym, input logic last);
        ld_valid = 1'b1;
        ld_sym   = sym;
        ld_last  = last;
        #1;
        chk("send_ld_ready", int'(ld_ready), 1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        fill_req   = v.fr;
        fill_addr  = v.fa;
        trace_req  = v.tr;
        trace_addr = v.ta;
        #1;
        chk($sformatf("v%0d_fill_gnt", idx), int'(fill_gnt), int'(v.egf));
        chk($sformatf("v%0d_trace_gnt", idx), int'(trace_gnt), int'(v.egt));
        tick();
        chk($sformatf("v%0d_dout_valid", idx), int'(dout_valid), int'(v.edv));
        chk($sformatf("v%0d_dout", idx), int'(dout), int'(v.ed));
        if (v.edv) begin
            chk($sformatf("v%0d_owner", idx), int'(dout_owner), int'(v.eo));
            chk($sformatf("v%0d_oob", idx), int'(dout_oob), int'(v.eoob));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ld_ready"}, int'(ld_ready), 0);
        chk({tag, "_ld_err"}, int'(ld_err), 0);
        chk({tag, "_dout_valid"}, int'(dout_valid), 0);
        chk({tag, "_dout"}, int'(dout), 0);
        chk({tag, "_owner"}, int'(dout_owner), 0);
        chk({tag, "_oob"}, int'(dout_oob), 0);
        chk({tag, "_seq_len"}, int'(seq_len), 0);
        chk({tag, "_loaded"}, int'(seq_loaded), 0);
    endtask

    initial begin
        logic [2:0] exp_syms [5];
        logic [2:0] small_syms [5];
        exp_syms   = '{3'b001, 3'b100, 3'b011, 3'b001, 3'b110};
        small_syms = '{3'b001, 3'b110, 3'b100, 3'b011, 3'b001};

        // tie phase: fill addr1 (A) vs trace addr3 (G), fill wins first after reset
        tab1[0] = '{1'b1, 7'd1, 1'b1, 7'd3, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0};
        tab1[1] = '{1'b1, 7'd1, 1'b1, 7'd3, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0};
        tab1[2] = '{1'b1, 7'd1, 1'b1, 7'd3, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0};
        tab1[3] = '{1'b1, 7'd1, 1'b1, 7'd3, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            tab1[4+i] = '{1'b1, 7'(i), 1'b0, 7'd0, 1'b1, 1'b0, 1'b1, exp_syms[i], 1'b0, 1'b0};
        end
        tab1[9]  = '{1'b0, 7'd0,   1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0};
        tab1[10] = '{1'b0, 7'd0,   1'b1, 7'd5, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1};
        tab1[11] = '{1'b0, 7'd0,   1'b1, 7'd4, 1'b0, 1'b1, 1'b1, 3'b110, 1'b1, 1'b0};
        tab1[12] = '{1'b1, 7'd127, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1};
        tab2[0]  = '{1'b1, 7'd1,   1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0};
        tab2[1]  = '{1'b1, 7'd2,   1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_vals("reset");
        fill_req = 1'b1;
        #1;
        chk("idle_fill_gnt", int'(fill_gnt), 0);
        fill_req = 1'b0;

        // G,A,T,G,C with last on C
        start_load();
        for (int i = 0; i < 5; i++) send(exp_syms[i], i == 4);
        chk("l1_seq_len", int'(seq_len), 5);
        chk("l1_loaded", int'(seq_loaded), 1);
        chk("l1_err", int'(ld_err), 0);
        chk("l1_ld_ready", int'(ld_ready), 0);
        for (int i = 0; i < 13; i++) apply_vec(tab1[i], i);
        fill_req  = 1'b0;
        trace_req = 1'b0;

        // G, invalid, A(last)
        start_load();
        send(3'b001, 1'b0);
        send(3'b111, 1'b0);
        chk("l2_err_mid", int'(ld_err), 1);
        send(3'b100, 1'b1);
        chk("l2_seq_len", int'(seq_len), 2);
        chk("l2_err", int'(ld_err), 1);
        chk("l2_loaded", int'(seq_loaded), 1);
        for (int i = 0; i < 2; i++) apply_vec(tab2[i], 20 + i);

        // ld_start in READY while fill requests
        fill_req  = 1'b1;
        fill_addr = 7'd0;
        ld_start  = 1'b1;
        #1;
        chk("abort_fill_gnt", int'(fill_gnt), 0);
        tick();
        ld_start = 1'b0;
        chk("abort_seq_len", int'(seq_len), 0);
        chk("abort_loaded", int'(seq_loaded), 0);
        chk("abort_ld_ready", int'(ld_ready), 1);
        chk("abort_dout_valid", int'(dout_valid), 0);
        chk("abort_err", int'(ld_err), 0);
        #1;
        chk("load_fill_gnt", int'(fill_gnt), 0);
        fill_req = 1'b0;

        // reset the cycle after a grant
        send(3'b001, 1'b0);
        send(3'b100, 1'b1);
        fill_req  = 1'b1;
        fill_addr = 7'd1;
        #1;
        chk("pre_rst_gnt", int'(fill_gnt), 1);
        tick();
        fill_req = 1'b0;
        rst      = 1'b1;
        chk("pre_rst_dvalid", int'(dout_valid), 1);
        chk("pre_rst_dout", int'(dout), 4);
        tick();
        chk_reset_vals("rst_mid");
        fill_req = 1'b1;
        #1;
        chk("rst_fill_gnt", int'(fill_gnt), 0);
        fill_req = 1'b0;
        rst      = 1'b0;
        tick();

        // N=5 instance: six symbols, no last
        s_ld_start = 1'b1;
        tick();
        s_ld_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_ld_valid = 1'b1;
            s_ld_sym   = small_syms[i];
            #1;
            chk($sformatf("small_ready%0d", i), int'(s_ld_ready), 1);
            tick();
        end
        chk("small_loaded", int'(s_seq_loaded), 1);
        chk("small_ld_ready", int'(s_ld_ready), 0);
        chk("small_len5", int'(s_seq_len), 5);
        s_ld_sym = 3'b001;
        tick();
        s_ld_valid = 1'b0;
        chk("small_len6", int'(s_seq_len), 5);
        chk("small_err", int'(s_ld_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
